// File: rtl/dfm_pkg.sv
// Shared constants for the frequency meter datapath.
package dfm_pkg;

   // Per-channel measurement mode encoding.
   localparam logic MODE_CLK_CNT  = 1'b0;  // count clk cycles while gate is high
   localparam logic MODE_EDGE_CNT = 1'b1;  // count sig rising edges while gate is high

   // Default counter/result width per channel.
   localparam int DEFAULT_CNT_W = 28;

endpackage : dfm_pkg

// File: rtl/gate_counter_ch.sv
// One measurement channel: input synchronizers, gate/sig edge detection,
// saturating window counter and the published result registers.
module gate_counter_ch
   import dfm_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W,
   parameter int SYNC  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_gate,
   input  logic             i_sig,
   input  logic             i_mode,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_ovf,
   output logic             o_valid,
   output logic             o_busy
);

   logic             w_gs;        // synchronized gate
   logic             w_ss;        // synchronized sig
   logic             r_gsd;       // w_gs delayed one cycle
   logic             r_ssd;       // w_ss delayed one cycle
   logic             r_mode;      // mode captured at window open
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic [CNT_W-1:0] r_cnt_out;
   logic             r_ovf_out;
   logic             r_valid;
   logic             r_busy;

   logic             w_rise;
   logic             w_high;
   logic             w_fall;
   logic             w_sig_rise;
   logic             w_inc;

   if (SYNC == 0) begin : g_nosync
      // Inputs are already clk-synchronous; use them directly.
      assign w_gs = i_gate;
      assign w_ss = i_sig;
   end else begin : g_sync
      logic [SYNC-1:0] r_gate_sync;
      logic [SYNC-1:0] r_sig_sync;

      // Shift gate and sig through SYNC flops; the MSB is the synchronized value.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_gate_sync <= '0;
            r_sig_sync  <= '0;
         end else begin
            r_gate_sync <= (r_gate_sync << 1) | SYNC'(i_gate);
            r_sig_sync  <= (r_sig_sync << 1) | SYNC'(i_sig);
         end
      end

      assign w_gs = r_gate_sync[SYNC-1];
      assign w_ss = r_sig_sync[SYNC-1];
   end

   assign w_rise     =  w_gs & ~r_gsd;
   assign w_high     =  w_gs &  r_gsd;
   assign w_fall     = ~w_gs &  r_gsd;
   assign w_sig_rise =  w_ss & ~r_ssd;

   // While the window is open, the latched mode decides what one step is.
   assign w_inc = (r_mode == MODE_EDGE_CNT) ? w_sig_rise : 1'b1;

   // Window state machine: open on gate rise, count while high, publish on fall.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: every register here, internal or output, is cleared by reset so a
      // window cut short by reset can never publish a stale partial count.
      if (rst) begin
         r_gsd     <= 1'b0;
         r_ssd     <= 1'b0;
         r_mode    <= MODE_CLK_CNT;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_cnt_out <= '0;
         r_ovf_out <= 1'b0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every branch sees last cycle's
         // r_gsd/r_cnt, not values updated earlier in this same block.
         r_gsd   <= w_gs;
         r_ssd   <= w_ss;
         r_valid <= 1'b0;
         if (w_rise) begin
            r_mode <= i_mode;
            r_cnt  <= (i_mode == MODE_CLK_CNT) ? CNT_W'(1) : CNT_W'(w_sig_rise);
            r_ovf  <= 1'b0;
            r_busy <= 1'b1;
         end else if (w_high) begin
            if (w_inc) begin
               if (&r_cnt) begin
                  r_ovf <= 1'b1;               // saturate: counter already all-ones
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
         end else if (w_fall) begin
            r_cnt_out <= r_cnt;
            r_ovf_out <= r_ovf;
            r_valid   <= 1'b1;
            r_busy    <= 1'b0;
         end
      end
   end

   assign o_cnt   = r_cnt_out;
   assign o_ovf   = r_ovf_out;
   assign o_valid = r_valid;
   assign o_busy  = r_busy;

endmodule : gate_counter_ch

// File: rtl/multi_gate_counter.sv
// Multi-channel gated counter: N_CH independent gate_counter_ch instances;
// this level only slices the per-channel buses.
module multi_gate_counter
   import dfm_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = DEFAULT_CNT_W,
   parameter int SYNC  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       gate,
   input  logic [N_CH-1:0]       sig,
   input  logic [N_CH-1:0]       mode,
   output logic [N_CH*CNT_W-1:0] cnt_out,
   output logic [N_CH-1:0]       ovf_out,
   output logic [N_CH-1:0]       valid,
   output logic [N_CH-1:0]       busy
);

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      gate_counter_ch #(
         .CNT_W (CNT_W),
         .SYNC  (SYNC)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .i_gate  (gate[c]),
         .i_sig   (sig[c]),
         .i_mode  (mode[c]),
         .o_cnt   (cnt_out[c*CNT_W +: CNT_W]),
         .o_ovf   (ovf_out[c]),
         .o_valid (valid[c]),
         .o_busy  (busy[c])
      );
   end

endmodule : multi_gate_counter

// File: doc/multi_gate_counter.md
# multi_gate_counter

Parametrised, multi-channel gated counter for the digital frequency meter datapath. Each channel measures one gate window: either the number of `clk` cycles the gate is high (gate-width/period mode) or the number of rising edges of a per-channel measured signal while the gate is high (frequency mode). On each gate falling edge the channel publishes a result with a one-cycle valid strobe and an overflow flag. The block sits between the gate generator and the result-to-frequency arithmetic and display logic.

## Interface
- `N_CH`, default 4: number of independent channels (1–16).
- `CNT_W`, default 28: counter/result width per channel.
- `SYNC`, default 2: synchronizer depth on `gate` and `sig`; 0 means inputs are already `clk`-synchronous (bypass).
- `clk  in  1`: sole clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `gate  in  N_CH`: per-channel measurement window, high = measure.
- `sig  in  N_CH`: per-channel measured signal (used in mode 1 only); frequency < f_clk/2.
- `mode  in  N_CH`: per-channel mode; 0 = count clk cycles, 1 = count `sig` rising edges.
- `cnt_out  out  N_CH*CNT_W`: last completed result; channel c occupies bits [c*CNT_W +: CNT_W].
- `ovf_out  out  N_CH`: overflow flag belonging to the current `cnt_out` of that channel.
- `valid  out  N_CH`: one-cycle pulse when that channel's `cnt_out`/`ovf_out` update.
- `busy  out  N_CH`: high while a window is open (synchronized gate seen high).

## Operation
- Per channel: gs = gate after SYNC flops, gsd = gs delayed 1 cycle; ss/ssd likewise for `sig`; sig_rise = ss & ~ssd.
- rise (gsd=0, gs=1): latch `mode[c]` into the channel mode register; cnt <= 1 in mode 0, cnt <= sig_rise in mode 1; ovf <= 0; busy <= 1.
- high (gsd=1, gs=1): mode 0: cnt + 1; mode 1: cnt + sig_rise. If the increment would exceed 2^CNT_W−1, cnt holds all-ones (saturate) and ovf <= 1.
- fall (gsd=1, gs=0): cnt_out <= cnt, ovf_out <= ovf, valid pulses for 1 cycle, busy <= 0. The fall cycle itself is not counted.
- low (gsd=0, gs=0): idle; cnt holds; outputs hold.
- Mode-0 result = number of cycles gs was high. Mode-1 result = sig rising edges detected while gs was high, including the rise cycle.
- `mode` changes during an open window are ignored until the next rise.
- Channels are fully independent; simultaneous events on different channels are handled in the same cycle.

## Timing
- Reset values: cnt_out = 0, ovf_out = 0, valid = 0, busy = 0. Internal cnt, ovf, mode register and all sync/delay flops are 0.
- `valid`/`cnt_out` update at the (SYNC+1)th rising `clk` edge at which `gate` is sampled low after being high.
- `busy` rises at the (SYNC+1)th edge at which `gate` is sampled high after being low.
- A 1-cycle synchronized gate pulse gives a result of 1 in mode 0.
- Back-to-back windows (gate low for 1 synchronized cycle) are both measured. Each produces its own valid pulse.
- Reset mid-window discards the measurement: no valid pulse, and cnt_out reverts to 0.
- If `gate` is already high when `rst` deasserts, a rise is detected SYNC+1 edges later and a partial window is measured. This behaviour is intended.
- Saturation: once ovf is set, cnt stays all-ones until the next rise.

## Structure
- `dfm_pkg`: constants MODE_CLK_CNT = 1'b0, MODE_EDGE_CNT = 1'b1, and the default CNT_W.
- Sub-module `gate_counter_ch`: one channel, containing synchronizers, edge detect, counter, saturation and output registers. It is instantiated N_CH times in a generate loop. The top level only slices buses.

## Test plan
- Mode 0, SYNC=2, ch0: gate high for 100 cycles, then low. Expect cnt_out[0] = 100, ovf_out[0] = 0, and one valid pulse exactly 3 edges after gate is sampled low.
- Mode 1, ch1: sig toggles every 5 clk cycles (period 10), gate high for 1000 cycles. Expect cnt_out[1] = 100 ±1, and ch0/ch2/ch3 outputs unchanged.
- CNT_W=8, mode 0: gate high for 300 cycles. Expect cnt_out = 255 and ovf_out = 1. A following 10-cycle window then gives 10 with ovf_out = 0.
- Mode change mid-window: mode=0 at rise, switched to 1 after 20 cycles, gate high 50 cycles. Expect result 50 (mode-0 count).
- Reset mid-window: assert `rst` 30 cycles into a window. Expect all outputs 0 immediately (async) and no valid pulse. The next 40-cycle window gives 40.
- Simultaneous falls on all 4 channels with windows of 5, 6, 7 and 8 cycles. Expect valid = 4'b1111 in one cycle and results 5/6/7/8.
